// File: rtl/load_block.sv
// load_block: streams a loadSize x loadSize tile from a fixed-latency word memory into loadOut.
// Build option LOAD_ZERO_FILL_EN clears buffer entries beyond the new tile in the cycle after accept.
module load_block #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int MAX_WORDS = 1024,
  parameter int MEM_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_SZ-1:0]        loadAddr,
  input  logic [DATA_SZ-1:0]        loadSize,
  output logic signed [DATA_SZ-1:0] loadOut [0:MAX_WORDS-1],
  output logic                      loadDone,
  output logic                      loadOverflow,
  output logic                      memRead,
  output logic [ADDR_SZ-1:0]        memAddr,
  input  logic [DATA_SZ-1:0]        memData
);
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int PRD_W = 2 * DATA_SZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          k_q, k_d;
  logic [ADDR_SZ-1:0]        addr_q, addr_d;
  logic                      rd_q, rd_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [MEM_LAT-1:0]        vld_q;
  logic [IDX_W-1:0]          tag_q [MEM_LAT];
  logic signed [DATA_SZ-1:0] buf_q [MAX_WORDS];
  logic [PRD_W-1:0]          prod_s;
  logic                      pend_s;

  // Reads still in flight other than the one returning this cycle.
  always_comb begin
    pend_s = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      pend_s = pend_s | vld_q[i];
    end
  end

  // Next-state and datapath update for the request FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    k_d     = k_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    prod_s  = {{DATA_SZ{1'b0}}, loadSize} * {{DATA_SZ{1'b0}}, loadSize};
    case (state_q)
      IDLE: begin
        if (loadEnable) begin
          k_d = '0;
          if (prod_s > PRD_W'(MAX_WORDS)) begin
            ovf_d   = 1'b1;
            count_d = CNT_W'(MAX_WORDS);
          end else begin
            ovf_d   = 1'b0;
            count_d = prod_s[CNT_W-1:0];
          end
          // An empty tile skips the memory entirely and leaves memAddr untouched.
          if (prod_s == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            rd_d    = 1'b0;
          end else begin
            state_d = ISSUE;
            rd_d    = 1'b1;
            addr_d  = loadAddr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (k_q == count_q - CNT_W'(1)) begin
          rd_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          k_d    = k_q + CNT_W'(1);
          addr_d = addr_q + ADDR_SZ'(1);
        end
      end
      DRAIN: begin
        if (!pend_s) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Valid/index tag pipeline matching the memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_q;
      tag_q[0] <= k_q[IDX_W-1:0];
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

`ifdef LOAD_ZERO_FILL_EN
  logic fill_q;

  // Marks the cycle after accept, when the tail of the buffer is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= (state_q == IDLE) && loadEnable;
    end
  end
`endif

  // Tile buffer: returning words land at their tagged index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_WORDS; i++) begin
`ifdef LOAD_ZERO_FILL_EN
        if (fill_q && (CNT_W'(i) >= count_q)) begin
          buf_q[i] <= '0;
        end else
`endif
        if (vld_q[MEM_LAT-1] && (tag_q[MEM_LAT-1] == IDX_W'(i))) begin
          buf_q[i] <= $signed(memData);
        end
      end
    end
  end

  assign loadOut      = buf_q;
  assign loadDone     = done_q;
  assign loadOverflow = ovf_q;
  assign memRead      = rd_q;
  assign memAddr      = addr_q;

endmodule

// File: tb/tb_load_block.sv
// Directed bench for load_block: one instance with MEM_LAT=1 (u1) and one with MEM_LAT=3 (u3),
// each served by a word-equals-address memory model.
module tb_load_block;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en1 = 1'b0, en3 = 1'b0;
  logic [15:0] addr1 = 16'h0, addr3 = 16'h0;
  logic [15:0] size1 = 16'h0, size3 = 16'h0;
  logic signed [15:0] out1 [0:1023];
  logic signed [15:0] out3 [0:1023];
  logic        done1, done3, ovf1, ovf3, rd1, rd3;
  logic [15:0] maddr1, maddr3, mdata1, mdata3;
  logic [15:0] m1_q;
  logic [15:0] m3_q [3];
  logic [15:0] alog [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;
  int          nrd;

  always #5 clk = ~clk;

  load_block #(.DATA_SZ(16), .ADDR_SZ(16), .MAX_WORDS(1024), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(rst), .loadEnable(en1), .loadAddr(addr1), .loadSize(size1),
    .loadOut(out1), .loadDone(done1), .loadOverflow(ovf1), .memRead(rd1),
    .memAddr(maddr1), .memData(mdata1)
  );

  load_block #(.DATA_SZ(16), .ADDR_SZ(16), .MAX_WORDS(1024), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(rst), .loadEnable(en3), .loadAddr(addr3), .loadSize(size3),
    .loadOut(out3), .loadDone(done3), .loadOverflow(ovf3), .memRead(rd3),
    .memAddr(maddr3), .memData(mdata3)
  );

  // Memory models: word value equals its address, returned MEM_LAT cycles after the strobe.
  always @(posedge clk) begin
    m1_q    <= maddr1;
    m3_q[0] <= maddr3;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign mdata1 = m1_q;
  assign mdata3 = m3_q[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input bit which, input int lo, input int hi,
                         input logic [15:0] base, input bit zero);
    int nbad;
    logic [15:0] e, o;
    nbad = 0;
    for (int i = lo; i <= hi; i++) begin
      e = zero ? 16'h0000 : base + 16'(i);
      o = which ? out3[i] : out1[i];
      if (o !== e) nbad++;
    end
    chk(tag, nbad, 0);
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] base, input int n);
    int nbad;
    nbad = 0;
    for (int k = 0; k < n && k < alog.size(); k++) begin
      if (alog[k] !== base + 16'(k)) nbad++;
    end
    chk(tag, nbad, 0);
  endtask

  // Called at a negedge; accepts on the (lead+1)-th following posedge, then measures
  // the accept-to-loadDone latency and logs every issued read address.
  task automatic req(input bit which, input logic [15:0] a, input logic [15:0] s,
                     input int lead, output int lat_o, output int nrd_o);
    if (which) begin
      en3 = 1'b1; addr3 = a; size3 = s;
    end else begin
      en1 = 1'b1; addr1 = a; size1 = s;
    end
    repeat (lead + 1) @(posedge clk);
    @(negedge clk);
    en1 = 1'b0;
    en3 = 1'b0;
    alog.delete();
    lat_o = 1;
    while (!(which ? done3 : done1) && lat_o < 4000) begin
      if (which ? rd3 : rd1) alog.push_back(which ? maddr3 : maddr1);
      @(negedge clk);
      lat_o++;
    end
    nrd_o = alog.size();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd", {rd3, rd1}, 0);
    chk("rst_done", {done3, done1}, 0);
    chk("rst_ovf", {ovf3, ovf1}, 0);
    chk("rst_maddr", maddr1, 0);
    chk_buf("rst_buf1", 1'b0, 0, 1023, 16'h0, 1'b1);
    chk_buf("rst_buf3", 1'b1, 0, 1023, 16'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // 5x5 tile, MEM_LAT=1
    req(1'b0, 16'h0100, 16'd5, 0, lat, nrd);
    chk("t5_lat", lat, 27);
    chk("t5_nrd", nrd, 25);
    chk_seq("t5_addr", 16'h0100, 25);
    chk("t5_ovf", ovf1, 0);
    chk_buf("t5_buf", 1'b0, 0, 24, 16'h0100, 1'b0);
    @(negedge clk);
    chk("t5_pulse", done1, 0);

    // 32x32 then back-to-back 5x5, MEM_LAT=3
    req(1'b1, 16'h2000, 16'd32, 0, lat, nrd);
    chk("t32_lat", lat, 1028);
    chk("t32_nrd", nrd, 1024);
    chk_seq("t32_addr", 16'h2000, 1024);
    chk("t32_ovf", ovf3, 0);
    chk_buf("t32_buf", 1'b1, 0, 1023, 16'h2000, 1'b0);
    req(1'b1, 16'h0500, 16'd5, 1, lat, nrd);
    chk("b2b_lat", lat, 29);
    chk("b2b_nrd", nrd, 25);
    chk_buf("b2b_buf", 1'b1, 0, 24, 16'h0500, 1'b0);
`ifdef LOAD_ZERO_FILL_EN
    chk_buf("b2b_tail", 1'b1, 25, 1023, 16'h0, 1'b1);
`else
    chk_buf("b2b_tail", 1'b1, 25, 1023, 16'h2000, 1'b0);
`endif
    @(negedge clk);

    // Overflow: 33x33 clamps to 1024 words
    req(1'b0, 16'h4000, 16'd33, 0, lat, nrd);
    chk("ovf_lat", lat, 1026);
    chk("ovf_nrd", nrd, 1024);
    chk("ovf_flag", ovf1, 1);
    chk_buf("ovf_buf", 1'b0, 0, 1023, 16'h4000, 1'b0);
    @(negedge clk);
    chk("ovf_hold", ovf1, 1);

    // Zero size: no reads, done the cycle after accept, overflow cleared
    req(1'b0, 16'h1234, 16'd0, 0, lat, nrd);
    chk("zero_lat", lat, 1);
    chk("zero_nrd", nrd, 0);
    chk("zero_ovf", ovf1, 0);
    @(negedge clk);

    // Address wrap
    req(1'b0, 16'hFFFE, 16'd2, 0, lat, nrd);
    chk("wrap_lat", lat, 6);
    chk("wrap_nrd", nrd, 4);
    chk_seq("wrap_addr", 16'hFFFE, 4);
    chk_buf("wrap_buf", 1'b0, 0, 3, 16'hFFFE, 1'b0);
    @(negedge clk);

    // Reset at read 10 of a 32x32 load
    en1 = 1'b1; addr1 = 16'h3000; size1 = 16'd32;
    @(posedge clk);
    @(negedge clk);
    en1 = 1'b0;
    nrd = 0;
    lat = 0;
    while (nrd < 10 && lat < 100) begin
      if (rd1) nrd++;
      if (nrd < 10) @(negedge clk);
      lat++;
    end
    chk("mid_reads", nrd, 10);
    rst = 1'b0;
    #1;
    chk("mid_rd", rd1, 0);
    chk("mid_done", done1, 0);
    chk("mid_maddr", maddr1, 0);
    chk_buf("mid_buf", 1'b0, 0, 1023, 16'h0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req(1'b0, 16'h0700, 16'd3, 0, lat, nrd);
    chk("r3_lat", lat, 11);
    chk("r3_nrd", nrd, 9);
    chk_seq("r3_addr", 16'h0700, 9);
    chk_buf("r3_buf", 1'b0, 0, 8, 16'h0700, 1'b0);
    chk_buf("r3_tail", 1'b0, 9, 1023, 16'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
